neuron_mac_sequencer: RTL

//  Sequences one neuron evaluation over the coefficient register bank: on Start, steps an index

---
 rtl/neuron_mac_sequencer_pkg.sv | 37 +++
 rtl/nn_sat_adder.sv | 30 +++
 rtl/neuron_mac_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared definitions for the neuron MAC sequencer: FSM encoding, default Q-format
// constants and the clamp used when narrowing wide sums back to the data width.
package neuron_mac_sequencer_pkg;

  localparam int unsigned DefWidth     = 32;
  localparam int unsigned DefNumCoeff  = 20;
  localparam int unsigned DefFracBits  = 16;
  localparam int unsigned DefGuardBits = 6;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StBias,
    StDone
  } state_e;

  // Clamp a signed value to the two's complement range of 'width' bits (width <= 63).
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int unsigned width,
                                                      output logic ovf);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    ovf = 1'b0;
    sat_to_width = value;
    if (value > max_v) begin
      sat_to_width = max_v;
      ovf = 1'b1;
    end else if (value < min_v) begin
      sat_to_width = min_v;
      ovf = 1'b1;
    end
  endfunction

endpackage

// File: rtl/nn_sat_adder.sv
// Signed add of a guarded accumulator and a data-width addend, clamped to the data width.
// Shared with the activation stage.
module nn_sat_adder
  import neuron_mac_sequencer_pkg::*;
#(
  parameter int unsigned Width     = DefWidth,
  parameter int unsigned GuardBits = DefGuardBits
) (
  input  logic signed [Width+GuardBits-1:0] acc_i,
  input  logic signed [Width-1:0]           addend_i,
  output logic signed [Width-1:0]           sum_o,
  output logic                              ovf_o
);

  // One extra bit so the add itself can never wrap before the clamp.
  localparam int unsigned SumW = Width + GuardBits + 1;

  logic signed [SumW-1:0] sum_full;
  logic signed [63:0]     clamped;
  logic                   ovf;

  // Full-precision sum, then clamp to the output range.
  always_comb begin
    sum_full = SumW'(acc_i) + SumW'(addend_i);
    clamped  = sat_to_width(64'(sum_full), Width, ovf);
    sum_o    = Width'(clamped);
    ovf_o    = ovf;
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Steps CoeffSel through the coefficient bank, accumulates CoeffIn*XIn in Q format,
// adds Offset and publishes a saturated Result with a one-cycle Done pulse.
module neuron_mac_sequencer
  import neuron_mac_sequencer_pkg::*;
#(
  parameter int unsigned Width     = DefWidth,
  parameter int unsigned NumCoeff  = DefNumCoeff,
  parameter int unsigned FracBits  = DefFracBits,
  parameter int unsigned GuardBits = DefGuardBits
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  output logic [4:0]       CoeffSel,
  input  logic [Width-1:0] CoeffIn,
  input  logic [Width-1:0] XIn,
  input  logic [Width-1:0] Offset,
  output logic             ResetStart,
  output logic             Busy,
  output logic             Done,
  output logic [Width-1:0] Result,
  output logic             Overflow
);

  localparam int unsigned AccW    = Width + GuardBits;
  localparam int unsigned ProdW   = 2 * Width;
  localparam logic [4:0]  LastSel = 5'(NumCoeff - 1);

  state_e                  state_q, state_d;
  logic [4:0]              sel_q, sel_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic signed [AccW-1:0]  prod_q, prod_d;
  logic                    pvalid_q, pvalid_d;
  logic                    start_q;
  logic                    rst_start_q, rst_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [Width-1:0]        result_q, result_d;
  logic                    request;
  logic signed [ProdW-1:0] prod_full;
  logic signed [Width-1:0] sat_sum;
  logic                    sat_ovf;

  assign request   = Start & ~start_q;
  assign prod_full = ProdW'($signed(CoeffIn)) * ProdW'($signed(XIn));

  nn_sat_adder #(
    .Width     (Width),
    .GuardBits (GuardBits)
  ) u_sat_adder (
    .acc_i    (acc_q),
    .addend_i ($signed(Offset)),
    .sum_o    (sat_sum),
    .ovf_o    (sat_ovf)
  );

  // Next-state and datapath update; Abort overrides everything except Result/Overflow.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    pvalid_d    = pvalid_q;
    rst_start_d = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    ovf_d       = ovf_q;

    // The product register lags the index by one cycle, so accumulation trails it.
    if (pvalid_q) acc_d = acc_q + prod_q;

    unique case (state_q)
      StIdle: begin
        if (request) begin
          state_d = StRun;
          acc_d   = '0;
          sel_d   = '0;
        end
      end
      StRun: begin
        prod_d   = AccW'(prod_full >>> FracBits);
        pvalid_d = 1'b1;
        if (sel_q == LastSel) state_d = StDrain;
        else                  sel_d   = sel_q + 5'd1;
      end
      StDrain: begin
        pvalid_d = 1'b0;
        state_d  = StBias;
      end
      StBias: begin
        result_d    = sat_sum;
        ovf_d       = sat_ovf;
        done_d      = 1'b1;
        rst_start_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        sel_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (Abort) begin
      state_d     = StIdle;
      sel_d       = '0;
      acc_d       = '0;
      pvalid_d    = 1'b0;
      rst_start_d = 1'b1;
      done_d      = 1'b0;
      result_d    = result_q;
      ovf_d       = ovf_q;
    end

    busy_d = state_d inside {StRun, StDrain, StBias};
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      pvalid_q    <= 1'b0;
      start_q     <= 1'b0;
      rst_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      pvalid_q    <= pvalid_d;
      start_q     <= Start;
      rst_start_q <= rst_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  assign CoeffSel   = sel_q;
  assign ResetStart = rst_start_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Result     = result_q;
  assign Overflow   = ovf_q;

endmodule
